// File: rtl/drowsiness_alert_fsm_pkg.sv
// Shared definitions for the drowsiness alert path: FSM state encodings and
// the level codes seen by the HMI and logging blocks.
package drowsiness_alert_fsm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_NORMAL = 2'd0;
  localparam state_t ST_WARN   = 2'd1;
  localparam state_t ST_ALARM  = 2'd2;
  localparam state_t ST_ACKED  = 2'd3;

  localparam logic [1:0] LEVEL_NORMAL = 2'd0;
  localparam logic [1:0] LEVEL_WARN   = 2'd1;
  localparam logic [1:0] LEVEL_ALARM  = 2'd2;

  // ACKED is still an alarm level as far as the driver display is concerned.
  function automatic logic [1:0] state_to_level(input state_t st);
    logic [1:0] lvl;
    case (st)
      ST_NORMAL: lvl = LEVEL_NORMAL;
      ST_WARN:   lvl = LEVEL_WARN;
      ST_ALARM:  lvl = LEVEL_ALARM;
      ST_ACKED:  lvl = LEVEL_ALARM;
      default:   lvl = LEVEL_NORMAL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/drowsiness_alert_fsm_if.sv
// Sample/ack inputs and HMI outputs of the drowsiness alert block.
// master = window-mean stage / HMI side, slave = the alert FSM.
interface drowsiness_alert_fsm_if;
  import drowsiness_alert_fsm_pkg::*;

  logic [7:0] avg;
  logic       sample_en;
  logic       ack;
  logic [1:0] level;
  logic       level_chg;
  logic       buzzer;

  modport master (
    output avg, sample_en, ack,
    input  level, level_chg, buzzer
  );

  modport slave (
    input  avg, sample_en, ack,
    output level, level_chg, buzzer
  );
endinterface

// File: rtl/drowsiness_alert_fsm_beep_gen.sv
// Buzzer square-wave generator: starts high on start, toggles every BEEP_HALF
// cycles while running, forced low on stop. Output is a flop.
module drowsiness_alert_fsm_beep_gen #(
  parameter int BEEP_HALF = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic buzzer
);

  localparam logic [7:0] HALF_LAST = 8'(BEEP_HALF - 1);

  logic       run_q, run_d;
  logic       buz_q, buz_d;
  logic [7:0] cnt_q, cnt_d;

  // Next-state for run flag, half-period counter and buzzer level.
  always_comb begin
    run_d = run_q;
    buz_d = buz_q;
    cnt_d = cnt_q;
    if (start) begin
      run_d = 1'b1;
      buz_d = 1'b1;
      cnt_d = 8'd0;
    end else if (stop) begin
      run_d = 1'b0;
      buz_d = 1'b0;
      cnt_d = 8'd0;
    end else if (run_q) begin
      if (cnt_q == HALF_LAST) begin
        cnt_d = 8'd0;
        buz_d = ~buz_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      buz_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      run_q <= run_d;
      buz_q <= buz_d;
      cnt_q <= cnt_d;
    end
  end

  assign buzzer = buz_q;

endmodule

// File: rtl/drowsiness_alert_fsm.sv
// Drowsiness alert FSM: turns the smoothed drowsiness score into a 3-level
// alert with threshold hysteresis, a consecutive-sample dwell and an
// acknowledgeable buzzer. All outputs come straight from flops.
module drowsiness_alert_fsm
  import drowsiness_alert_fsm_pkg::*;
#(
  parameter int WARN_TH   = 96,
  parameter int ALARM_TH  = 160,
  parameter int HYST      = 16,
  parameter int DWELL     = 4,
  parameter int BEEP_HALF = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  drowsiness_alert_fsm_if.slave       bus
);

  // Reject parameter sets that would make the thresholds wrap or the
  // counters unable to reach their terminal values.
  if (!(HYST >= 0 && HYST <= WARN_TH && WARN_TH < ALARM_TH && ALARM_TH <= 255 &&
        DWELL >= 1 && DWELL <= 255 && BEEP_HALF >= 1 && BEEP_HALF <= 255)) begin : g_param_check
    $error("drowsiness_alert_fsm: illegal parameter combination");
  end

  // Thresholds at 9 bits so the hysteresis subtraction can never wrap.
  localparam logic [8:0] WARN_UP_TH  = 9'(WARN_TH);
  localparam logic [8:0] WARN_DN_TH  = 9'(WARN_TH - HYST);
  localparam logic [8:0] ALARM_UP_TH = 9'(ALARM_TH);
  localparam logic [8:0] ALARM_DN_TH = 9'(ALARM_TH - HYST);
  localparam logic [7:0] DWELL_C     = 8'(DWELL);

  state_t     state_q, state_d, smp_state_s;
  logic [7:0] dwell_q, dwell_d, smp_dwell_s;
  logic       dir_dn_q, dir_dn_d, smp_dir_dn_s;
  logic [1:0] level_q, level_d;
  logic       level_chg_q, level_chg_d;
  logic [8:0] avg9_s;
  logic       warn_up_s, warn_dn_s, alarm_up_s, alarm_dn_s;
  logic [7:0] cnt_inc_s, run_len_s;
  logic       ack_take_s;
  logic       beep_start_s, beep_stop_s;

  assign avg9_s     = {1'b0, bus.avg};
  assign warn_up_s  = (avg9_s >= WARN_UP_TH);
  assign alarm_up_s = (avg9_s >= ALARM_UP_TH);
  assign warn_dn_s  = (avg9_s <  WARN_DN_TH);
  assign alarm_dn_s = (avg9_s <  ALARM_DN_TH);
  assign cnt_inc_s  = dwell_q + 8'd1;

  // In WARN the run length restarts at 1 when the sample flips the tracked
  // direction (dir_dn_q: 0 = counting up-samples, 1 = counting down-samples).
  always_comb begin
    run_len_s = cnt_inc_s;
    if (alarm_up_s) begin
      run_len_s = dir_dn_q ? 8'd1 : cnt_inc_s;
    end else if (warn_dn_s) begin
      run_len_s = dir_dn_q ? cnt_inc_s : 8'd1;
    end else begin
      run_len_s = 8'd0;
    end
  end

  // Sample-driven next state and dwell count; holds when no new sample.
  always_comb begin
    smp_state_s  = state_q;
    smp_dwell_s  = dwell_q;
    smp_dir_dn_s = dir_dn_q;
    if (bus.sample_en) begin
      case (state_q)
        ST_NORMAL: begin
          if (!warn_up_s) begin
            smp_dwell_s = 8'd0;
          end else if (cnt_inc_s == DWELL_C) begin
            smp_state_s = ST_WARN;
            smp_dwell_s = 8'd0;
          end else begin
            smp_dwell_s = cnt_inc_s;
          end
          smp_dir_dn_s = 1'b0;
        end
        ST_WARN: begin
          if (!(alarm_up_s || warn_dn_s)) begin
            smp_dwell_s  = 8'd0;
            smp_dir_dn_s = 1'b0;
          end else if (run_len_s == DWELL_C) begin
            smp_state_s  = alarm_up_s ? ST_ALARM : ST_NORMAL;
            smp_dwell_s  = 8'd0;
            smp_dir_dn_s = 1'b0;
          end else begin
            smp_dwell_s  = run_len_s;
            smp_dir_dn_s = warn_dn_s;
          end
        end
        ST_ALARM, ST_ACKED: begin
          if (!alarm_dn_s) begin
            smp_dwell_s = 8'd0;
          end else if (cnt_inc_s == DWELL_C) begin
            smp_state_s = ST_WARN;
            smp_dwell_s = 8'd0;
          end else begin
            smp_dwell_s = cnt_inc_s;
          end
          smp_dir_dn_s = 1'b0;
        end
        default: begin
          smp_state_s  = ST_NORMAL;
          smp_dwell_s  = 8'd0;
          smp_dir_dn_s = 1'b0;
        end
      endcase
    end else begin
      smp_state_s  = state_q;
      smp_dwell_s  = dwell_q;
      smp_dir_dn_s = dir_dn_q;
    end
  end

  // ack only matters in ALARM and loses to a completing de-escalation.
  assign ack_take_s = bus.ack && (state_q == ST_ALARM) && (smp_state_s == ST_ALARM);

  // Final next state, level and level-change pulse.
  always_comb begin
    if (ack_take_s) begin
      state_d  = ST_ACKED;
      dwell_d  = 8'd0;
      dir_dn_d = 1'b0;
    end else begin
      state_d  = smp_state_s;
      dwell_d  = smp_dwell_s;
      dir_dn_d = smp_dir_dn_s;
    end
    level_d     = state_to_level(state_d);
    level_chg_d = (level_d != level_q);
  end

  // FSM, dwell and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      dwell_q     <= 8'd0;
      dir_dn_q    <= 1'b0;
      level_q     <= LEVEL_NORMAL;
      level_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      dir_dn_q    <= dir_dn_d;
      level_q     <= level_d;
      level_chg_q <= level_chg_d;
    end
  end

  assign beep_start_s = (state_d == ST_ALARM) && (state_q != ST_ALARM);
  assign beep_stop_s  = (state_q == ST_ALARM) && (state_d != ST_ALARM);

  drowsiness_alert_fsm_beep_gen #(
    .BEEP_HALF (BEEP_HALF)
  ) u_beep_gen (
    .clk    (clk),
    .rst    (rst),
    .start  (beep_start_s),
    .stop   (beep_stop_s),
    .buzzer (bus.buzzer)
  );

  assign bus.level     = level_q;
  assign bus.level_chg = level_chg_q;

endmodule

// File: tb/tb_drowsiness_alert_fsm.sv
// Directed self-checking bench for drowsiness_alert_fsm with default parameters.
module tb_drowsiness_alert_fsm;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  drowsiness_alert_fsm_if dif ();

  drowsiness_alert_fsm #(
    .WARN_TH   (96),
    .ALARM_TH  (160),
    .HYST      (16),
    .DWELL     (4),
    .BEEP_HALF (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sample strobe; outputs of that edge are visible when this returns.
  task automatic sample(input logic [7:0] a, input logic k);
    @(negedge clk);
    dif.avg       = a;
    dif.sample_en = 1'b1;
    dif.ack       = k;
    @(negedge clk);
    dif.sample_en = 1'b0;
    dif.ack       = 1'b0;
  endtask

  task automatic samples(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) sample(a, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", dif.level); end
    tests_run++;
    if (dif.level_chg !== 1'b0) begin tests_failed++; $display("FAIL reset_chg got %0b exp 0", dif.level_chg); end
    tests_run++;
    if (dif.buzzer !== 1'b0) begin tests_failed++; $display("FAIL reset_buzzer got %0b exp 0", dif.buzzer); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dwell_restart();
    samples(8'd100, 3);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL dw_3of4 got %0d exp 0", dif.level); end
    sample(8'd90, 1'b0);
    samples(8'd100, 3);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL dw_broken_run got %0d exp 0", dif.level); end
    sample(8'd100, 1'b0);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL dw_warn got %0d exp 1", dif.level); end
    tests_run++;
    if (dif.level_chg !== 1'b1) begin tests_failed++; $display("FAIL dw_chg_pulse got %0b exp 1", dif.level_chg); end
    @(negedge clk);
    tests_run++;
    if (dif.level_chg !== 1'b0) begin tests_failed++; $display("FAIL dw_chg_width got %0b exp 0", dif.level_chg); end
  endtask

  task automatic test_escalate();
    int bad;
    do_reset();
    samples(8'd170, 4);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL esc_warn got %0d exp 1", dif.level); end
    samples(8'd170, 3);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL esc_7 got %0d exp 1", dif.level); end
    sample(8'd170, 1'b0);
    tests_run++;
    if (dif.level !== 2'd2 || dif.level_chg !== 1'b1) begin
      tests_failed++; $display("FAIL esc_alarm got level=%0d chg=%0b exp level=2 chg=1", dif.level, dif.level_chg);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (dif.buzzer !== (((i / 8) % 2) == 0)) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL esc_buzz_pattern got %0d wrong cycles exp 0", bad); end
  endtask

  task automatic test_ack();
    @(negedge clk);
    dif.ack = 1'b1;
    @(negedge clk);
    dif.ack = 1'b0;
    tests_run++;
    if (dif.buzzer !== 1'b0 || dif.level !== 2'd2 || dif.level_chg !== 1'b0) begin
      tests_failed++; $display("FAIL ack_enter got buz=%0b level=%0d chg=%0b exp 0/2/0", dif.buzzer, dif.level, dif.level_chg);
    end
    samples(8'd150, 10);
    tests_run++;
    if (dif.level !== 2'd2) begin tests_failed++; $display("FAIL ack_hold150 got %0d exp 2", dif.level); end
    samples(8'd140, 4);
    tests_run++;
    if (dif.level !== 2'd1 || dif.level_chg !== 1'b1 || dif.buzzer !== 1'b0) begin
      tests_failed++; $display("FAIL ack_to_warn got level=%0d chg=%0b buz=%0b exp 1/1/0", dif.level, dif.level_chg, dif.buzzer);
    end
  endtask

  task automatic test_hysteresis();
    samples(8'd85, 10);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL hys_hold85 got %0d exp 1", dif.level); end
    for (int i = 0; i < 3; i++) begin
      sample(8'd79, 1'b0);
      repeat (2 + i) @(negedge clk);
    end
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL hys_gap3 got %0d exp 1", dif.level); end
    sample(8'd79, 1'b0);
    tests_run++;
    if (dif.level !== 2'd0 || dif.level_chg !== 1'b1) begin
      tests_failed++; $display("FAIL hys_normal got level=%0d chg=%0b exp 0/1", dif.level, dif.level_chg);
    end
  endtask

  task automatic test_ack_vs_dwell();
    samples(8'd170, 8);
    tests_run++;
    if (dif.level !== 2'd2 || dif.buzzer !== 1'b1) begin
      tests_failed++; $display("FAIL avd_alarm got level=%0d buz=%0b exp 2/1", dif.level, dif.buzzer);
    end
    samples(8'd140, 3);
    sample(8'd140, 1'b1);
    tests_run++;
    if (dif.level !== 2'd1 || dif.buzzer !== 1'b0 || dif.level_chg !== 1'b1) begin
      tests_failed++; $display("FAIL avd_dn_wins got level=%0d buz=%0b chg=%0b exp 1/0/1", dif.level, dif.buzzer, dif.level_chg);
    end
    dif.ack = 1'b1;
    repeat (3) @(negedge clk);
    dif.ack = 1'b0;
    tests_run++;
    if (dif.level !== 2'd1 || dif.level_chg !== 1'b0) begin
      tests_failed++; $display("FAIL avd_ack_ignored got level=%0d chg=%0b exp 1/0", dif.level, dif.level_chg);
    end
  endtask

  task automatic test_reset_mid_alarm();
    do_reset();
    samples(8'd170, 8);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (dif.level !== 2'd0 || dif.buzzer !== 1'b0 || dif.level_chg !== 1'b0) begin
      tests_failed++; $display("FAIL rma_async got level=%0d buz=%0b chg=%0b exp 0/0/0", dif.level, dif.buzzer, dif.level_chg);
    end
    @(negedge clk);
    rst = 1'b0;
    samples(8'd100, 3);
    do_reset();
    sample(8'd100, 1'b0);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL rma_dwell_cleared got %0d exp 0", dif.level); end
    samples(8'd100, 3);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL rma_normal_after got %0d exp 1", dif.level); end
  endtask

  task automatic test_thresholds();
    do_reset();
    samples(8'd95, 4);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL th_95 got %0d exp 0", dif.level); end
    samples(8'd96, 4);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL th_96 got %0d exp 1", dif.level); end
    samples(8'd79, 3);
    sample(8'd160, 1'b0);
    samples(8'd79, 3);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL th_run_restart got %0d exp 1", dif.level); end
    sample(8'd79, 1'b0);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL th_restart_done got %0d exp 0", dif.level); end
    samples(8'd96, 4);
    samples(8'd160, 4);
    tests_run++;
    if (dif.level !== 2'd2 || dif.buzzer !== 1'b1) begin
      tests_failed++; $display("FAIL th_160 got level=%0d buz=%0b exp 2/1", dif.level, dif.buzzer);
    end
    samples(8'd144, 4);
    tests_run++;
    if (dif.level !== 2'd2) begin tests_failed++; $display("FAIL th_144 got %0d exp 2", dif.level); end
    samples(8'd143, 3);
    @(negedge clk);
    dif.ack = 1'b1;
    @(negedge clk);
    dif.ack = 1'b0;
    samples(8'd200, 8);
    tests_run++;
    if (dif.level !== 2'd2 || dif.buzzer !== 1'b0 || dif.level_chg !== 1'b0) begin
      tests_failed++; $display("FAIL th_acked_stays got level=%0d buz=%0b chg=%0b exp 2/0/0", dif.level, dif.buzzer, dif.level_chg);
    end
    samples(8'd143, 4);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL th_143 got %0d exp 1", dif.level); end
    samples(8'd80, 4);
    tests_run++;
    if (dif.level !== 2'd1) begin tests_failed++; $display("FAIL th_80 got %0d exp 1", dif.level); end
    samples(8'd79, 4);
    tests_run++;
    if (dif.level !== 2'd0) begin tests_failed++; $display("FAIL th_79 got %0d exp 0", dif.level); end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b0;
    dif.avg       = 8'd0;
    dif.sample_en = 1'b0;
    dif.ack       = 1'b0;
    test_reset();
    test_dwell_restart();
    test_escalate();
    test_ack();
    test_hysteresis();
    test_ack_vs_dwell();
    test_reset_mid_alarm();
    test_thresholds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
